// File: rtl/alu_trace_pkg.sv
// Shared types and constants for the ALU result trace transmitter.
package alu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int   BITS_PER_BYTE  = 8;
    localparam int   BYTES_PER_WORD = 4;
    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;

endpackage

// File: rtl/alu_trace_fifo.sv
// 32-bit synchronous FIFO with first-word-fall-through head; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module alu_trace_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [31:0]                  i_data,
    input  logic                         i_pop,
    output logic [31:0]                  o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(FIFO_DEPTH):0]  o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Depth is a power of two, so the count MSB alone marks full.
    assign o_full    = r_count[AW];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/alu_trace_tx.sv
// Captures ALU results into a FIFO and sends each word as four 8N1 UART bytes,
// LSB byte first. Optional ALU_TRACE_CHANGE_ONLY_EN skips repeated values.
module alu_trace_tx
    import alu_trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  result_i,
    input  logic                         result_valid_i,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic                         overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);

    localparam int         CW        = $clog2(CLKS_PER_BIT);
    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_e        r_state;
    logic [CW-1:0] r_cyc;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic [31:0]   r_shift;
    logic          r_tx;
    logic          r_ovf;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_cyc_end;
    logic [31:0]   w_head;

`ifdef ALU_TRACE_CHANGE_ONLY_EN
    logic [31:0] r_last;

    assign w_req = result_valid_i & (result_i != r_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_last <= '0;
        else if (w_push) r_last <= result_i;
    end
`else
    assign w_req = result_valid_i;
`endif

    assign w_cyc_end = (r_cyc == CW'(CLKS_PER_BIT - 1));
    // Pops happen only when a new word starts: from IDLE, or straight after byte 3's stop bit.
    assign w_pop  = ~w_empty & ((r_state == ST_IDLE) |
                    ((r_state == ST_STOP) & w_cyc_end & (r_byte == LAST_BYTE)));
    assign w_push = w_req & (~w_full | w_pop);

    assign tx_o       = r_tx;
    assign busy_o     = (r_state != ST_IDLE);
    assign overflow_o = r_ovf;

    alu_trace_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (result_i),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count_o)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        r_ovf <= 1'b0;
        else if (w_req & w_full & ~w_pop)  r_ovf <= 1'b1;
    end

    // Shift register is pure data; the low bit is always the next data bit to send.
    always_ff @(posedge clk) begin
        if (w_pop)                                  r_shift <= w_head;
        else if ((r_state == ST_DATA) & w_cyc_end)  r_shift <= {1'b0, r_shift[31:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_tx    <= STOP_BIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_START;
                        r_cyc   <= '0;
                        r_byte  <= '0;
                        r_tx    <= START_BIT;
                    end
                end
                ST_START: begin
                    if (w_cyc_end) begin
                        r_state <= ST_DATA;
                        r_cyc   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_cyc_end) begin
                        r_cyc <= '0;
                        if (r_bit == LAST_BIT) begin
                            r_state <= ST_STOP;
                            r_tx    <= STOP_BIT;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_cyc_end) begin
                        r_cyc <= '0;
                        if (r_byte != LAST_BYTE) begin
                            r_byte  <= r_byte + 1'b1;
                            r_state <= ST_START;
                            r_tx    <= START_BIT;
                        end else if (!w_empty) begin
                            r_byte  <= '0;
                            r_state <= ST_START;
                            r_tx    <= START_BIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_trace_tx.md
# alu_trace_tx

Debug trace transmitter on the processor's result output. Captures 32-bit ALU results presented by `MIPS_Processor` on a strobe, buffers them in a small FIFO and serialises each word as four 8N1 UART bytes on a single pin. It is the consumer end of the `alu_result_o` interface, so result streams can be logged off-chip on hardware instead of only in simulation.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: words of buffering; must be a power of 2 and ≥ 2.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `result_i`  input  32  ALU result from the processor (`alu_result_o`).
- `result_valid_i`  input  1  capture strobe; sampled every rising edge.
- `tx_o`  output  1  UART serial output; idle level is 1.
- `busy_o`  output  1  high while a frame is being shifted out.
- `overflow_o`  output  1  sticky; set when a word is dropped because the FIFO is full.
- `fifo_count_o`  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

## Operation
- Reset (asserted low, asynchronous): `tx_o`=1, `busy_o`=0, `overflow_o`=0, `fifo_count_o`=0. The FIFO is emptied, the FSM goes to IDLE and all counters clear. Reset asserted mid-frame aborts the frame and forces `tx_o` to 1 immediately.
- Capture: the word is pushed when `result_valid_i`=1 and the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the word is dropped and `overflow_o` is set. It stays set until reset.
  - A push and a pop in the same cycle are both accepted, including when the FIFO is full; the count is unchanged.
- Byte order: byte0 = `result_i[7:0]` is sent first, then [15:8], [23:16], [31:24]. Bits within a byte are sent LSB first.
- Frame: one start bit (0), 8 data bits, one stop bit (1). Each bit is held exactly `CLKS_PER_BIT` cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The head word is popped into a 32-bit shift register and the byte index is set to 0.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START after `CLKS_PER_BIT` cycles if the byte index < 3; the index increments.
  - STOP → START after byte 3 if the FIFO is non-empty; the next word is popped in that cycle.
  - STOP → IDLE after byte 3 otherwise.
- `busy_o` = 1 in every state except IDLE.
- Counters: the bit-cycle counter counts 0..CLKS_PER_BIT-1 and wraps; the bit index counts 0..7; the byte index counts 0..3. The FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.

## Timing
- Push at edge N:
  - the word is counted in `fifo_count_o` after edge N;
  - if the FSM is IDLE, the pop and `tx_o` falling happen at edge N+1.
- Word duration: 40·`CLKS_PER_BIT` cycles.
- Back-to-back words: there is no idle gap. The start bit of the next word follows the stop bit of byte 3 directly.
- Sustained throughput: one word per 40·`CLKS_PER_BIT` cycles. A faster strobe fills the FIFO and then drops words.
- `tx_o` is a registered output with no combinational path from any input.

## Configuration
- `ALU_TRACE_CHANGE_ONLY_EN` defined:
  - a push additionally requires `result_i` ≠ the last captured value;
  - the last-captured register resets to 0 and updates only on an accepted push;
  - a strobe with an unchanged value is neither pushed nor counted as an overflow.
- `ALU_TRACE_CHANGE_ONLY_EN` undefined: every strobe attempts a push, and no compare register is built.

## Structure
- Package `alu_trace_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `BITS_PER_BYTE`=8;
  - `BYTES_PER_WORD`=4;
  - `START_BIT`=1'b0;
  - `STOP_BIT`=1'b1.
- Sub-module `alu_trace_fifo`: synchronous 32-bit FIFO with push, pop, full, empty, count and first-word-fall-through head. It is parameterised by `FIFO_DEPTH` and uses the same clk/reset.
- The top level contains the capture logic, the overflow flag, the FSM, the counters and the shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset then idle for 20 cycles → `tx_o`=1, `busy_o`=0, `fifo_count_o`=0, `overflow_o`=0.
- Single strobe with `result_i`=32'h12345678 → `tx_o` falls one cycle after the push; decoded bytes are 78, 56, 34, 12; `busy_o` falls 160 cycles after going high.
- Strobe 6 consecutive cycles with values 1..6 → words 1..5 are transmitted in order with no gap, word 6 is dropped, and `overflow_o`=1 from the cycle of the sixth strobe until reset.
- Reset asserted during byte 2 of a word → `tx_o`=1 and `busy_o`=0 immediately; after release, no further bytes appear and `fifo_count_o`=0.
- Push while full in the same cycle the FSM pops (count 4) → the word is accepted, the count stays 4, and `overflow_o` stays 0.
- With `ALU_TRACE_CHANGE_ONLY_EN` defined, strobe values 5, 5, 7 → only words 5 and 7 are transmitted, and `overflow_o`=0.
